// File: rtl/adc_frame_feeder_if.sv
`default_nettype none
// ============================================================================
// Module : adc_frame_feeder_if
// Brief  : Control, sample and word-output bundle between the ADC frame
//          feeder and its environment (sequencer, ADC front end, packer).
// Rev    : 1.0  initial release
// ============================================================================
interface adc_frame_feeder_if;
    logic        start;
    logic        stop;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        finish_to480;
    logic        en;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        err;

    modport master (
        output start, stop, adc_data, adc_valid, finish_to480,
        input  en, data_out, data_valid, busy, frame_cnt, err
    );

    modport slave (
        input  start, stop, adc_data, adc_valid, finish_to480,
        output en, data_out, data_valid, busy, frame_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/adc_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module : adc_frame_feeder
// Brief  : Box-averages groups of DECIM 12-bit ADC samples into 16-bit words
//          and paces them out in frames, waiting for the packer acknowledge
//          plus a hold-off between frames.
//          Optional macro ADC_FEEDER_TAG_EN puts word-index-mod-16 in [15:12].
// Rev    : 1.0  initial release
// ============================================================================
module adc_frame_feeder #(
    parameter int          DECIM          = 4,
    parameter int          LOG2_DECIM     = 2,
    parameter int          FRAME_WORDS    = 240,
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd50_000_000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    adc_frame_feeder_if.slave    bus
);

    localparam int c_GW = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int c_AW = 12 + LOG2_DECIM;
    localparam int c_WW = ($clog2(FRAME_WORDS + 1) > 4) ? $clog2(FRAME_WORDS + 1) : 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_HOLDOFF  = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_AW-1:0]   r_acc;
    logic [c_GW-1:0]   r_grp;
    logic [c_WW-1:0]   r_word;
    logic [31:0]       r_hold;
    logic              r_en;
    logic              r_dv;
    logic              r_busy;
    logic              r_err;
    logic [15:0]       r_dout;
    logic [7:0]        r_fcnt;

    logic [c_AW-1:0]   w_sum;
    logic [11:0]       w_avg;
    logic [3:0]        w_tag;
    logic              w_last_smp;
    logic              w_last_word;

    // The accumulator holds at most DECIM-1 samples, so adding the closing
    // sample still fits in 12+LOG2_DECIM bits.
    assign w_sum       = r_acc + c_AW'(bus.adc_data);
    assign w_avg       = w_sum[LOG2_DECIM +: 12];
    assign w_last_smp  = (r_grp == c_GW'(DECIM - 1));
    assign w_last_word = (r_word == c_WW'(FRAME_WORDS - 1));

`ifdef ADC_FEEDER_TAG_EN
    assign w_tag = r_word[3:0];
`else
    assign w_tag = 4'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_grp   <= '0;
            r_word  <= '0;
            r_hold  <= '0;
            r_en    <= 1'b0;
            r_dv    <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
            r_fcnt  <= '0;
        end else begin
            r_dv <= 1'b0;
            if (bus.stop) begin
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_grp   <= '0;
                r_word  <= '0;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_acc  <= '0;
                        r_grp  <= '0;
                        r_word <= '0;
                        if (bus.start) begin
                            r_state <= S_RUN;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // An acknowledge before the frame is complete is flagged only.
                        if (bus.finish_to480) begin
                            r_err <= 1'b1;
                        end
                        if (bus.adc_valid) begin
                            if (w_last_smp) begin
                                r_dout <= {w_tag, w_avg};
                                r_dv   <= 1'b1;
                                r_acc  <= '0;
                                r_grp  <= '0;
                                if (w_last_word) begin
                                    r_state <= S_WAIT_ACK;
                                    r_word  <= '0;
                                end else begin
                                    r_word <= r_word + 1'b1;
                                end
                            end else begin
                                r_acc <= w_sum;
                                r_grp <= r_grp + 1'b1;
                            end
                        end
                    end
                    S_WAIT_ACK: begin
                        if (bus.finish_to480) begin
                            r_state <= S_HOLDOFF;
                            r_en    <= 1'b0;
                            r_fcnt  <= r_fcnt + 1'b1;
                            r_hold  <= '0;
                        end
                    end
                    S_HOLDOFF: begin
                        // Zero hold-off still spends one cycle here.
                        if (r_hold == HOLDOFF_CYCLES) begin
                            r_state <= S_RUN;
                            r_en    <= 1'b1;
                            r_word  <= '0;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.en         = r_en;
    assign bus.data_out   = r_dout;
    assign bus.data_valid = r_dv;
    assign bus.busy       = r_busy;
    assign bus.frame_cnt  = r_fcnt;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_frame_feeder
// Brief  : Self-checking bench: directed scenarios plus random traffic checked
//          every cycle against a queue-based behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_adc_frame_feeder;

    localparam int          DECIM = 4;
    localparam int          FW    = 240;
    localparam logic [31:0] HOLD  = 32'd10;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_WAIT = 2;
    localparam int M_HOLD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_frame_feeder_if bus();

    adc_frame_feeder #(
        .DECIM          (DECIM),
        .LOG2_DECIM     (2),
        .FRAME_WORDS    (FW),
        .HOLDOFF_CYCLES (HOLD)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] words_q[$];

    // Behavioural model: pending group kept as a sample queue, frame phase as a mode.
    int          m_mode   = M_IDLE;
    int          m_words  = 0;
    int          m_cyc    = 0;
    int          m_run_at = 0;
    int          m_grp[$];
    logic [15:0] m_dout   = '0;
    logic        m_dv     = 1'b0;
    logic        m_err    = 1'b0;
    logic [7:0]  m_fcnt   = '0;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_words = 0;
        m_grp.delete();
        m_dout  = '0;
        m_dv    = 1'b0;
        m_err   = 1'b0;
        m_fcnt  = '0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic fin,
                              input logic av, input logic [11:0] d);
        int         sum;
        logic [3:0] tag;
        m_dv = 1'b0;
        if (sp) begin
            m_mode  = M_IDLE;
            m_words = 0;
            m_grp.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (st) begin
                    m_mode  = M_RUN;
                    m_err   = 1'b0;
                    m_words = 0;
                    m_grp.delete();
                end
                M_RUN: begin
                    if (fin) m_err = 1'b1;
                    if (av) begin
                        m_grp.push_back(int'(d));
                        if (m_grp.size() == DECIM) begin
                            sum = 0;
                            foreach (m_grp[i]) sum += m_grp[i];
`ifdef ADC_FEEDER_TAG_EN
                            tag = 4'(m_words % 16);
`else
                            tag = 4'h0;
`endif
                            m_dout = {tag, 12'(sum / DECIM)};
                            m_dv   = 1'b1;
                            m_grp.delete();
                            m_words++;
                            if (m_words == FW) m_mode = M_WAIT;
                        end
                    end
                end
                M_WAIT: if (fin) begin
                    m_mode   = M_HOLD;
                    m_fcnt   = m_fcnt + 8'd1;
                    m_run_at = m_cyc + int'(HOLD) + 1;
                end
                default: if (m_cyc == m_run_at) begin
                    m_mode  = M_RUN;
                    m_words = 0;
                end
            endcase
        end
    endtask

    initial begin : compare
        logic [27:0] act;
        logic [27:0] exp;
        logic        e_en;
        logic        e_busy;
        forever begin
            @(posedge clk);
            m_cyc++;
            if (!rst_n) model_reset();
            else model_step(bus.start, bus.stop, bus.finish_to480, bus.adc_valid, bus.adc_data);
            #1;
            e_en   = (m_mode == M_RUN) || (m_mode == M_WAIT);
            e_busy = (m_mode != M_IDLE);
            exp = {e_en, e_busy, m_dv, m_err, m_fcnt, m_dout};
            act = {bus.en, bus.busy, bus.data_valid, bus.err, bus.frame_cnt, bus.data_out};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle %0d en/busy/dv/err/fcnt/dout: got %h required %h", m_cyc, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic sp, input logic fin,
                       input logic av, input logic [11:0] d);
        bus.start        = st;
        bus.stop         = sp;
        bus.finish_to480 = fin;
        bus.adc_valid    = av;
        bus.adc_data     = d;
        @(negedge clk);
        if (bus.data_valid) words_q.push_back(bus.data_out);
    endtask

    task automatic send(input logic [11:0] d);
        repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'(~d));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        bus.start = 1'b0; bus.stop = 1'b0; bus.finish_to480 = 1'b0;
        bus.adc_valid = 1'b0; bus.adc_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.en, bus.busy, bus.data_valid, bus.err, bus.frame_cnt, bus.data_out}), 32'd0);
        rst_n = 1'b1;

        // Samples outside RUN are ignored.
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'($urandom));
        chk("idle_no_words", 32'(words_q.size()), 32'd0);
        chk("idle_en_busy", 32'({bus.en, bus.busy}), 32'd0);
        chk("idle_dout", 32'(bus.data_out), 32'd0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        chk("start_busy_en", 32'({bus.en, bus.busy}), 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'd100);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'd101);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'd102);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'd103);
        chk("first_word_dv", 32'(bus.data_valid), 32'd1);
        chk("first_word", 32'(bus.data_out), 32'h0065);

        for (int w = 1; w < FW; w++) repeat (DECIM) send(12'hFFF);
        chk("frame_words", 32'(words_q.size()), 32'd240);
        chk("last_word_avg", 32'(words_q[239][11:0]), 32'hFFF);
`ifdef ADC_FEEDER_TAG_EN
        chk("tag_w15", 32'(words_q[15][15:12]), 32'hF);
        chk("tag_w16", 32'(words_q[16][15:12]), 32'h0);
        chk("tag_w17", 32'(words_q[17][15:12]), 32'h1);
`endif
        repeat (DECIM) send(12'hFFF);
        chk("wait_ack_no_word", 32'(words_q.size()), 32'd240);
        chk("wait_ack_en", 32'({bus.en, bus.busy}), 32'd3);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
        chk("ack_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("ack_en_low", 32'(bus.en), 32'd0);
        n = 0;
        while (!bus.en && n < 100) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'd7);
            n++;
        end
        chk("holdoff_len", 32'(n), 32'(HOLD + 1));

        // Stop mid-group (with a competing start) discards the partial sum.
        send(12'd900);
        send(12'd901);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 12'd902);
        chk("stop_idle", 32'({bus.en, bus.busy, bus.data_valid}), 32'd0);
        words_q.delete();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        repeat (DECIM) send(12'd8);
        chk("restart_words", 32'(words_q.size()), 32'd1);
        chk("restart_word", 32'(words_q[0]), 32'h0008);

        // Early acknowledge flags err but leaves the frame intact.
        repeat (5 * DECIM) send(12'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
        chk("early_ack_err", 32'({bus.err, bus.busy}), 32'd3);
        repeat ((FW - 6) * DECIM) send(12'($urandom));
        chk("err_frame_words", 32'(words_q.size()), 32'd240);
        chk("err_frame_wait", 32'(bus.en), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
        chk("ack2_frame_cnt", 32'(bus.frame_cnt), 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
        chk("err_sticky", 32'(bus.err), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        chk("err_cleared", 32'(bus.err), 32'd0);

        // Asynchronous reset in the middle of a frame.
        repeat (3 * DECIM) send(12'h123);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({bus.en, bus.busy, bus.data_valid, bus.err, bus.frame_cnt, bus.data_out}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 999) == 0),
                ($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7), 12'($urandom));
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
